frame_sequencer: RTL and testbench
==================================

# frame_sequencer

Control FSM that sequences one outgoing USB-style packet through the frame-assembly datapath (`combo`). It classifies the packet's PID and, for data packets, optionally runs the encryptor. It then runs the CRC16 unit, drives `combo`'s `data_sel`, waits for `combo`'s `ready`, and hands the assembled 88-bit frame (or the 8-bit PID-only frame) to the transmit shift register. It sits between the host-side packet interface and the `combo` / CRC / encryptor / TX-shifter blocks.

## Interface
- `TIMEOUT`, 255: cycles allowed in any wait state before abort; counter width is `$clog2(TIMEOUT+1)`.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `pkt_valid`  in  1  host offers a packet.
- `pkt_pid`  in  8  PID of offered packet.
- `encrypt_en`  in  1  encrypt the payload; sampled with `pkt_pid`.
- `pkt_ready`  out  1  sequencer can accept a packet (IDLE).
- `enc_start`  out  1  one-cycle start pulse to encryptor.
- `enc_done`  in  1  encryptor finished; `encrypted` is valid.
- `crc_start`  out  1  one-cycle start pulse to CRC16 unit.
- `crc_done`  in  1  CRC16 result valid.
- `data_sel`  out  3  to `combo`:
  - 3'b001 = PID only.
  - 3'b010 = PID + `data_in` + `CRC_in`.
  - 3'b011 = PID + `encrypted` + `CRC16_out`.
  - 3'b100 = idle (zero frame).
- `combo_ready`  in  1  `combo` `ready` output.
- `frame_load`  out  1  one-cycle load pulse to TX shifter.
- `frame_bits`  out  7  valid frame length: 88 or 8, or 0 when idle.
- `tx_done`  in  1  TX shifter finished the frame.
- `pkt_done`  out  1  one-cycle pulse: packet sent.
- `pid_err`  out  1  one-cycle pulse: PID check failed.
- `timeout_err`  out  1  one-cycle pulse: wait state expired.

## Operation
- States: IDLE, CHECK, ENC, CRC, ASSEMBLE, LOAD, SEND.
- IDLE:
  - `pkt_ready`=1 and `data_sel`=3'b100.
  - On `pkt_valid && pkt_ready`, capture `pkt_pid` and `encrypt_en`, then go to CHECK.
- CHECK (1 cycle):
  - The PID is valid iff `pid[7:4] == ~pid[3:0]`.
  - Invalid PID: pulse `pid_err`, go to IDLE.
  - DATA0 (0xC3) or DATA1 (0x4B) with encrypt set: go to ENC.
  - DATA0 or DATA1 with encrypt clear: go to ASSEMBLE with sel 3'b010.
  - Any other valid PID: go to ASSEMBLE with sel 3'b001.
- ENC:
  - `enc_start` pulses in the first cycle of the state.
  - On `enc_done`, go to CRC.
- CRC:
  - `crc_start` pulses in the first cycle of the state.
  - On `crc_done`, go to ASSEMBLE with sel 3'b011.
- ASSEMBLE:
  - `data_sel` holds the chosen code.
  - On `combo_ready`, go to LOAD.
- LOAD (1 cycle):
  - `frame_load`=1.
  - `frame_bits`=8 for sel 3'b001, otherwise 88.
  - Then go to SEND.
- SEND:
  - `data_sel` and `frame_bits` hold their values.
  - On `tx_done`, pulse `pkt_done` and go to IDLE.
- Timeout:
  - The wait counter clears on entry to ENC, CRC, ASSEMBLE or SEND and increments each cycle in those states.
  - When it reaches `TIMEOUT` with the awaited input still low, pulse `timeout_err` and go to IDLE.
  - The awaited input arriving on the same cycle as the limit wins: proceed normally, no error.
- Stray inputs:
  - `enc_done`, `crc_done`, `combo_ready` and `tx_done` are ignored outside their own wait state.
  - `pkt_valid` is ignored outside IDLE.
- All pulse outputs are registered, Moore-style; `data_sel` and `frame_bits` are registered.

## Timing
- Reset (async, any state): state=IDLE.
  - `pkt_ready`=1, `data_sel`=3'b100, `frame_bits`=0.
  - All pulses (`enc_start`, `crc_start`, `frame_load`, `pkt_done`, `pid_err`, `timeout_err`)=0.
  - Wait counter=0.
- A reset mid-packet abandons the packet with no error pulse.
- Accept at edge N:
  - CHECK in cycle N+1.
  - Non-data PID: ASSEMBLE in N+2; with `combo_ready` already high, `frame_load` in N+3 and SEND from N+4.
- Encrypted path:
  - `enc_start` asserts in cycle N+2.
  - `crc_start` asserts the cycle after `enc_done` is sampled.
  - ASSEMBLE starts the cycle after `crc_done` is sampled.
- `pkt_done` asserts the cycle after `tx_done` is sampled; `pkt_ready` returns in that same cycle.
- A new packet can be accepted in the cycle following `pkt_done`.

## Test plan
- Handshake path: PID 0xD2, `combo_ready` held at 1.
  - `data_sel`=3'b001 from N+2.
  - `frame_load` pulse at N+3 with `frame_bits`=8.
  - `tx_done` at N+6 gives `pkt_done` at N+7.
- Encrypted data path: PID 0xC3 with `encrypt_en`=1.
  - `enc_start` pulses once; `enc_done` after 10 cycles.
  - `crc_start` pulses once; `crc_done` after 4 cycles.
  - `data_sel`=3'b011 and `frame_bits`=88.
- Plain data path: PID 0x4B with `encrypt_en`=0.
  - No `enc_start` and no `crc_start`.
  - `data_sel`=3'b010 and `frame_bits`=88.
- Invalid PID: 0x25 (0x2 != ~0x5).
  - `pid_err` pulses in N+2.
  - Back in IDLE with `data_sel`=3'b100; no start pulses.
- Timeout with `TIMEOUT`=16: PID 0xC3 encrypted, `enc_done` never arrives.
  - `timeout_err` pulses once, 16 cycles into ENC.
  - Return to IDLE.
  - Repeat with `enc_done` on the limit cycle: no error, proceeds to CRC.
- Reset mid-SEND: assert `rst` asynchronously between clock edges.
  - Outputs reach their reset values immediately.
  - No `pkt_done`.
  - A packet offered after reset is accepted normally.

Source files
------------

// File: rtl/frame_sequencer.sv
// frame_sequencer: control FSM that walks one outgoing packet through
// PID classification, optional encryption, CRC, frame assembly in combo,
// and hand-off to the TX shift register. Every output is registered and
// is computed from the next state, so pulses line up with state entry.
module frame_sequencer #(
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pkt_valid,
  input  logic [7:0] pkt_pid,
  input  logic       encrypt_en,
  output logic       pkt_ready,
  output logic       enc_start,
  input  logic       enc_done,
  output logic       crc_start,
  input  logic       crc_done,
  output logic [2:0] data_sel,
  input  logic       combo_ready,
  output logic       frame_load,
  output logic [6:0] frame_bits,
  input  logic       tx_done,
  output logic       pkt_done,
  output logic       pid_err,
  output logic       timeout_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  // The wait counter starts at 0 on entry, so the last allowed wait cycle
  // is the one where it holds TIMEOUT-1.
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  localparam logic [2:0] SEL_PID  = 3'b001;
  localparam logic [2:0] SEL_DATA = 3'b010;
  localparam logic [2:0] SEL_ENC  = 3'b011;
  localparam logic [2:0] SEL_IDLE = 3'b100;

  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ENC,
    S_CRC,
    S_ASSEMBLE,
    S_LOAD,
    S_SEND
  } state_t;

  state_t          state_reg, state_next;
  logic [7:0]      pid_reg, pid_next;
  logic            enc_reg, enc_next;
  logic [2:0]      sel_reg, sel_next;
  logic [CW-1:0]   wait_cnt_reg, wait_cnt_next;

  logic            pkt_ready_reg, pkt_ready_next;
  logic            enc_start_reg, enc_start_next;
  logic            crc_start_reg, crc_start_next;
  logic            frame_load_reg, frame_load_next;
  logic            pkt_done_reg, pkt_done_next;
  logic            pid_err_reg, pid_err_next;
  logic            timeout_err_reg, timeout_err_next;
  logic [2:0]      data_sel_reg, data_sel_next;
  logic [6:0]      frame_bits_reg, frame_bits_next;

  logic            pid_ok;
  logic            pid_is_data;
  logic            wait_hit;

  assign pid_ok      = (pid_reg[7:4] == ~pid_reg[3:0]);
  assign pid_is_data = (pid_reg == PID_DATA0) || (pid_reg == PID_DATA1);
  assign wait_hit    = (wait_cnt_reg == LIMIT);

  // Next-state, wait counter and registered-output next values.
  always_comb begin
    state_next       = state_reg;
    pid_next         = pid_reg;
    enc_next         = enc_reg;
    sel_next         = sel_reg;
    wait_cnt_next    = wait_cnt_reg;
    enc_start_next   = 1'b0;
    crc_start_next   = 1'b0;
    frame_load_next  = 1'b0;
    pkt_done_next    = 1'b0;
    pid_err_next     = 1'b0;
    timeout_err_next = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (pkt_valid && pkt_ready_reg) begin
          pid_next   = pkt_pid;
          enc_next   = encrypt_en;
          state_next = S_CHECK;
        end
      end
      S_CHECK: begin
        wait_cnt_next = '0;
        if (!pid_ok) begin
          pid_err_next = 1'b1;
          state_next   = S_IDLE;
        end else if (pid_is_data && enc_reg) begin
          enc_start_next = 1'b1;
          sel_next       = SEL_ENC;
          state_next     = S_ENC;
        end else if (pid_is_data) begin
          sel_next   = SEL_DATA;
          state_next = S_ASSEMBLE;
        end else begin
          sel_next   = SEL_PID;
          state_next = S_ASSEMBLE;
        end
      end
      S_ENC: begin
        if (enc_done) begin
          crc_start_next = 1'b1;
          wait_cnt_next  = '0;
          state_next     = S_CRC;
        end else if (wait_hit) begin
          timeout_err_next = 1'b1;
          state_next       = S_IDLE;
        end else begin
          wait_cnt_next = wait_cnt_reg + CW'(1);
        end
      end
      S_CRC: begin
        if (crc_done) begin
          wait_cnt_next = '0;
          state_next    = S_ASSEMBLE;
        end else if (wait_hit) begin
          timeout_err_next = 1'b1;
          state_next       = S_IDLE;
        end else begin
          wait_cnt_next = wait_cnt_reg + CW'(1);
        end
      end
      S_ASSEMBLE: begin
        if (combo_ready) begin
          frame_load_next = 1'b1;
          state_next      = S_LOAD;
        end else if (wait_hit) begin
          timeout_err_next = 1'b1;
          state_next       = S_IDLE;
        end else begin
          wait_cnt_next = wait_cnt_reg + CW'(1);
        end
      end
      S_LOAD: begin
        wait_cnt_next = '0;
        state_next    = S_SEND;
      end
      S_SEND: begin
        if (tx_done) begin
          pkt_done_next = 1'b1;
          state_next    = S_IDLE;
        end else if (wait_hit) begin
          timeout_err_next = 1'b1;
          state_next       = S_IDLE;
        end else begin
          wait_cnt_next = wait_cnt_reg + CW'(1);
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Level outputs follow the state being entered.
    pkt_ready_next = (state_next == S_IDLE);
    if (state_next inside {S_ASSEMBLE, S_LOAD, S_SEND}) begin
      data_sel_next = sel_next;
    end else begin
      data_sel_next = SEL_IDLE;
    end
    if (state_next inside {S_LOAD, S_SEND}) begin
      frame_bits_next = (sel_next == SEL_PID) ? 7'd8 : 7'd88;
    end else begin
      frame_bits_next = 7'd0;
    end
  end

  // State, context and output registers; reset abandons any packet silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= S_IDLE;
      pid_reg         <= 8'h00;
      enc_reg         <= 1'b0;
      sel_reg         <= SEL_IDLE;
      wait_cnt_reg    <= '0;
      pkt_ready_reg   <= 1'b1;
      enc_start_reg   <= 1'b0;
      crc_start_reg   <= 1'b0;
      frame_load_reg  <= 1'b0;
      pkt_done_reg    <= 1'b0;
      pid_err_reg     <= 1'b0;
      timeout_err_reg <= 1'b0;
      data_sel_reg    <= SEL_IDLE;
      frame_bits_reg  <= 7'd0;
    end else begin
      state_reg       <= state_next;
      pid_reg         <= pid_next;
      enc_reg         <= enc_next;
      sel_reg         <= sel_next;
      wait_cnt_reg    <= wait_cnt_next;
      pkt_ready_reg   <= pkt_ready_next;
      enc_start_reg   <= enc_start_next;
      crc_start_reg   <= crc_start_next;
      frame_load_reg  <= frame_load_next;
      pkt_done_reg    <= pkt_done_next;
      pid_err_reg     <= pid_err_next;
      timeout_err_reg <= timeout_err_next;
      data_sel_reg    <= data_sel_next;
      frame_bits_reg  <= frame_bits_next;
    end
  end

  assign pkt_ready   = pkt_ready_reg;
  assign enc_start   = enc_start_reg;
  assign crc_start   = crc_start_reg;
  assign frame_load  = frame_load_reg;
  assign pkt_done    = pkt_done_reg;
  assign pid_err     = pid_err_reg;
  assign timeout_err = timeout_err_reg;
  assign data_sel    = data_sel_reg;
  assign frame_bits  = frame_bits_reg;

endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: randomized packets against a timeline model. The
// stimulus side computes, per packet, the cycle of every expected pulse
// (queued) and the expected level outputs per cycle; a monitor pops and
// compares whenever the DUT raises a pulse.
module tb_frame_sequencer;

  localparam int T    = 16;
  localparam int MAXC = 16384;

  // Pulse kinds; bit k of the monitor's pulse vector is kind k.
  localparam int K_ENC  = 0;
  localparam int K_CRC  = 1;
  localparam int K_LOAD = 2;
  localparam int K_DONE = 3;
  localparam int K_PERR = 4;
  localparam int K_TMO  = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pkt_valid = 1'b0;
  logic [7:0] pkt_pid = 8'h00;
  logic       encrypt_en = 1'b0;
  logic       pkt_ready;
  logic       enc_start;
  logic       enc_done = 1'b0;
  logic       crc_start;
  logic       crc_done = 1'b0;
  logic [2:0] data_sel;
  logic       combo_ready = 1'b0;
  logic       frame_load;
  logic [6:0] frame_bits;
  logic       tx_done = 1'b0;
  logic       pkt_done;
  logic       pid_err;
  logic       timeout_err;

  frame_sequencer #(.TIMEOUT(T)) dut (
    .clk         (clk),
    .rst         (rst),
    .pkt_valid   (pkt_valid),
    .pkt_pid     (pkt_pid),
    .encrypt_en  (encrypt_en),
    .pkt_ready   (pkt_ready),
    .enc_start   (enc_start),
    .enc_done    (enc_done),
    .crc_start   (crc_start),
    .crc_done    (crc_done),
    .data_sel    (data_sel),
    .combo_ready (combo_ready),
    .frame_load  (frame_load),
    .frame_bits  (frame_bits),
    .tx_done     (tx_done),
    .pkt_done    (pkt_done),
    .pid_err     (pid_err),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [2:0] exp_sel   [MAXC];
  logic [6:0] exp_bits  [MAXC];
  logic       exp_ready [MAXC];

  typedef struct {
    int kind;
    int cycle;
  } ev_t;
  ev_t evq[$];

  // Wait-phase windows for enc_done, crc_done, combo_ready, tx_done.
  int ws[4];
  int we[4];
  int wa[4];

  function automatic void chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, req);
    end
  endfunction

  function automatic void push_ev(int kind, int cycle);
    ev_t e;
    e.kind  = kind;
    e.cycle = cycle;
    evq.push_back(e);
  endfunction

  // A wait phase of input k starting at cycle 'start'; the input arrives
  // in the d-th cycle of the phase (0-based) unless d >= T. Returns the
  // cycle the next phase begins, or minus the IDLE-return cycle on timeout.
  function automatic int wait_phase(int k, int start, int d);
    ws[k] = start;
    if (d < T) begin
      we[k] = start + d + 1;
      wa[k] = start + d;
      return start + d + 1;
    end
    we[k] = start + T;
    wa[k] = -1;
    push_ev(K_TMO, start + T);
    return -(start + T);
  endfunction

  function automatic int rnd_delay();
    case ($urandom % 10)
      0:       return 0;
      1:       return T - 1;
      2:       return T + 3;
      default: return int'($urandom % 5);
    endcase
  endfunction

  task automatic check_idle_outputs(string tag);
    chk({tag, "_pkt_ready"}, int'(pkt_ready), 1);
    chk({tag, "_data_sel"}, int'(data_sel), 4);
    chk({tag, "_frame_bits"}, int'(frame_bits), 0);
    chk({tag, "_pulses"},
        int'({timeout_err, pid_err, pkt_done, frame_load, crc_start, enc_start}), 0);
  endtask

  task automatic drive_noise();
    pkt_valid   = 1'b0;
    pkt_pid     = 8'($urandom);
    encrypt_en  = 1'($urandom);
    enc_done    = ($urandom % 4) == 0;
    crc_done    = ($urandom % 4) == 0;
    combo_ready = ($urandom % 4) == 0;
    tx_done     = ($urandom % 4) == 0;
  endtask

  // One packet offered in the current cycle; abort_off >= 0 asserts rst
  // asynchronously in that cycle (relative to acceptance).
  task automatic run_packet(input logic [7:0] pid, input logic enc,
                            input int de, input int dcr, input int dasm,
                            input int dtx, input int abort_off);
    int n, t, end_c, asm_s, load_c;
    logic [2:0] sel;
    logic [6:0] bits;
    logic [3:0] v;
    bit ok, data;
    string res;
    n = cyc;
    for (int k = 0; k < 4; k++) begin
      ws[k] = 0; we[k] = 0; wa[k] = -1;
    end
    ok     = (pid[7:4] == ~pid[3:0]);
    data   = (pid == 8'hC3) || (pid == 8'h4B);
    sel    = 3'b100;
    bits   = 7'd0;
    asm_s  = 0;
    load_c = 0;
    res    = "sent";
    if (!ok) begin
      push_ev(K_PERR, n + 2);
      end_c = n + 2;
      res = "pid_err";
    end else begin
      sel  = !data ? 3'b001 : (enc ? 3'b011 : 3'b010);
      bits = (sel == 3'b001) ? 7'd8 : 7'd88;
      t = n + 2;
      if (data && enc) begin
        push_ev(K_ENC, t);
        t = wait_phase(0, t, de);
        if (t > 0) begin
          push_ev(K_CRC, t);
          t = wait_phase(1, t, dcr);
        end
      end
      if (t > 0) begin
        asm_s = t;
        t = wait_phase(2, t, dasm);
      end
      if (t > 0) begin
        load_c = t;
        push_ev(K_LOAD, t);
        t = wait_phase(3, t + 1, dtx);
        if (t > 0) push_ev(K_DONE, t);
      end
      end_c = (t > 0) ? t : -t;
      if (t < 0) res = "timeout";
    end
    for (int c = n + 1; c < end_c; c++) begin
      exp_ready[c] = 1'b0;
      if (asm_s > 0 && c >= asm_s) exp_sel[c] = sel;
      if (load_c > 0 && c >= load_c) exp_bits[c] = bits;
    end

    for (int c = n; c < end_c; c++) begin
      drive_noise();
      if (c == n) begin
        pkt_valid  = 1'b1;
        pkt_pid    = pid;
        encrypt_en = enc;
      end else begin
        pkt_valid  = ($urandom % 4) == 0;
      end
      for (int k = 0; k < 4; k++)
        v[k] = (c >= ws[k] && c < we[k]) ? (c == wa[k]) : 1'($urandom % 4 == 0);
      enc_done    = v[0];
      crc_done    = v[1];
      combo_ready = v[2];
      tx_done     = v[3];
      if (abort_off >= 0 && c == n + abort_off) begin
        #2 rst = 1'b1;
        #1 check_idle_outputs("async_reset");
        while (evq.size() > 0 && evq[$].cycle > c) void'(evq.pop_back());
        for (int cc = c + 1; cc <= end_c; cc++) begin
          exp_ready[cc] = 1'b1;
          exp_sel[cc]   = 3'b100;
          exp_bits[cc]  = 7'd0;
        end
        res = "reset";
        break;
      end
      @(negedge clk);
    end
    if (res == "reset") begin
      pkt_valid = 1'b0; enc_done = 1'b0; crc_done = 1'b0;
      combo_ready = 1'b0; tx_done = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
    end
    $display("pkt pid=%02h enc=%0d accepted@%0d -> %s", pid, enc, n, res);
  endtask

  // Monitor: level outputs every cycle, pulses against the event queue.
  initial begin
    logic [5:0] pulses;
    ev_t e;
    forever begin
      @(negedge clk);
      if (!rst && cyc < MAXC) begin
        chk("pkt_ready", int'(pkt_ready), int'(exp_ready[cyc]));
        chk("data_sel", int'(data_sel), int'(exp_sel[cyc]));
        chk("frame_bits", int'(frame_bits), int'(exp_bits[cyc]));
        while (evq.size() > 0 && evq[0].cycle < cyc) begin
          e = evq.pop_front();
          chk("missed_pulse_kind", -1, e.kind);
        end
        pulses = {timeout_err, pid_err, pkt_done, frame_load, crc_start, enc_start};
        for (int k = 0; k < 6; k++) begin
          if (pulses[k]) begin
            if (evq.size() == 0) begin
              chk("unexpected_pulse_kind", k, -1);
            end else begin
              e = evq.pop_front();
              chk("pulse_kind", k, e.kind);
              chk("pulse_cycle", cyc, e.cycle);
            end
          end
        end
      end
    end
  end

  // Stimulus: directed cases first, then random packets.
  initial begin
    logic [7:0] pid;
    logic [3:0] x;
    for (int i = 0; i < MAXC; i++) begin
      exp_sel[i]   = 3'b100;
      exp_bits[i]  = 7'd0;
      exp_ready[i] = 1'b1;
    end
    #2 rst = 1'b1;
    #1 check_idle_outputs("reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_packet(8'hD2, 1'b0, 0, 0, 0, 2, -1);        // handshake path
    run_packet(8'hC3, 1'b1, 9, 3, 1, 3, -1);        // encrypted data
    run_packet(8'h4B, 1'b0, 0, 0, 2, 1, -1);        // plain data
    run_packet(8'h25, 1'b0, 0, 0, 0, 0, -1);        // invalid PID
    run_packet(8'hC3, 1'b1, T + 4, 0, 0, 0, -1);    // ENC timeout
    run_packet(8'hC3, 1'b1, T - 1, 0, 0, 0, -1);    // enc_done on limit cycle
    run_packet(8'hD2, 1'b0, 0, 0, 0, 10, 6);        // reset mid-SEND
    run_packet(8'h4B, 1'b1, 0, 0, 0, 0, -1);        // accepted after reset
    run_packet(8'hA5, 1'b0, 0, 0, T, 0, -1);        // ASSEMBLE timeout
    run_packet(8'h4B, 1'b0, 0, 0, 0, T - 1, -1);    // tx_done on limit cycle
    run_packet(8'hC3, 1'b1, 0, T, 0, 0, -1);        // CRC timeout
    run_packet(8'h1E, 1'b1, 0, 0, 0, T, -1);        // SEND timeout

    for (int i = 0; i < 60; i++) begin
      case ($urandom % 4)
        0: pid = 8'hC3;
        1: pid = 8'h4B;
        2: begin x = 4'($urandom); pid = {~x, x}; end
        default: pid = 8'($urandom);
      endcase
      run_packet(pid, 1'($urandom), rnd_delay(), rnd_delay(), rnd_delay(),
                 rnd_delay(), -1);
      repeat ($urandom % 3) begin
        drive_noise();
        @(negedge clk);
      end
    end

    drive_noise();
    pkt_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("events_outstanding", evq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
